// File: rtl/attn_pkg.sv
// attn_pkg: shared types for the attention-score EPU sequencers.
package attn_pkg;
  typedef logic [31:0] fp32_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} rowmax_sched_st_e;
endpackage

// File: rtl/attn_rowmax_sched.sv
// attn_rowmax_sched: streams score rows into fp32_row_max and stores each row max.
module attn_rowmax_sched
  import attn_pkg::*;
#(
  parameter int T = 4,
  parameter int ROWS = 4,
  parameter int TIMEOUT = 64,
  localparam int RW = $clog2(ROWS),
  localparam int CW = (T > 1) ? $clog2(T) : 1,
  localparam int NW = $clog2(ROWS + 1),
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] cfg_rows,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sc_rd_en,
  output logic [RW-1:0] sc_rd_row,
  output logic [CW-1:0] sc_rd_col,
  input  fp32_t         sc_rd_data,
  output logic          rm_in_valid,
  output fp32_t         rm_in_fp32,
  output logic          rm_row_start,
  output logic          rm_row_last,
  input  logic          rm_max_valid,
  input  fp32_t         rm_max_fp32,
  output logic          mx_wr_en,
  output logic [RW-1:0] mx_wr_row,
  output fp32_t         mx_wr_data
);
  rowmax_sched_st_e r_st, w_nx;
  logic [NW-1:0] r_n, w_n;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [TW-1:0] r_tmo;
  fp32_t r_max;
  logic r_err, r_in_valid, r_row_start, r_row_last;
  logic w_col_last, w_row_last, w_tmo_last;
  assign w_n = (cfg_rows > NW'(ROWS)) ? NW'(ROWS) : cfg_rows;
  assign w_col_last = r_col == CW'(T - 1);
  assign w_row_last = NW'(r_row) == r_n - NW'(1);
  assign w_tmo_last = r_tmo == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_st <= IDLE;
    else r_st <= w_nx;
  always_comb begin
    w_nx = r_st;
    case (r_st)
      IDLE:    w_nx = !start ? IDLE : (w_n == '0) ? DONE : ISSUE;
      ISSUE:   w_nx = w_col_last ? WAIT : ISSUE;
      WAIT:    w_nx = rm_max_valid ? WRITE : w_tmo_last ? DONE : WAIT;
      WRITE:   w_nx = w_row_last ? DONE : ISSUE;
      default: w_nx = IDLE;
    endcase
    if (abort && r_st != IDLE) w_nx = IDLE;
  end
  // The alignment stage is cleared on abort so no stray beat reaches the datapath.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_n <= '0;
      r_row <= '0;
      r_col <= '0;
      r_tmo <= '0;
      r_max <= '0;
      r_err <= 1'b0;
      r_in_valid <= 1'b0;
      r_row_start <= 1'b0;
      r_row_last <= 1'b0;
    end else begin
      r_in_valid <= sc_rd_en && !abort;
      r_row_start <= sc_rd_en && !abort && r_col == '0;
      r_row_last <= sc_rd_en && !abort && w_col_last;
      r_tmo <= (r_st == WAIT) ? r_tmo + TW'(1) : '0;
      if (r_st == IDLE && start) begin
        r_n <= w_n;
        r_row <= '0;
        r_col <= '0;
        r_err <= 1'b0;
      end
      if (r_st == ISSUE) r_col <= w_col_last ? '0 : r_col + CW'(1);
      if (r_st == WAIT && rm_max_valid) r_max <= rm_max_fp32;
      if (r_st == WAIT && !rm_max_valid && w_tmo_last && !abort) r_err <= 1'b1;
      if (r_st == WRITE && !w_row_last && !abort) r_row <= r_row + RW'(1);
    end
  always_comb begin
    busy = r_st != IDLE;
    done = r_st == DONE;
    err = r_err;
    sc_rd_en = r_st == ISSUE;
    sc_rd_row = r_row;
    sc_rd_col = r_col;
    rm_in_valid = r_in_valid;
    rm_in_fp32 = sc_rd_data;
    rm_row_start = r_row_start;
    rm_row_last = r_row_last;
    mx_wr_en = r_st == WRITE;
    mx_wr_row = r_row;
    mx_wr_data = r_max;
  end
endmodule

// File: tb/tb_attn_rowmax_sched.sv
// tb_attn_rowmax_sched: scoreboard bench with a score memory and a behavioural row-max datapath.
module tb_attn_rowmax_sched;
  import attn_pkg::*;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [2:0] cfg_rows = 0;
  logic busy, done, err, sc_rd_en, rm_in_valid, rm_row_start, rm_row_last, mx_wr_en;
  logic [1:0] sc_rd_row, sc_rd_col, mx_wr_row;
  fp32_t sc_rd_data = '0, rm_in_fp32, rm_max_fp32 = '0, mx_wr_data;
  logic rm_max_valid = 0;
  logic stub_en = 1;
  fp32_t mem [4][4];
  fp32_t acc = '0;
  fp32_t m_nxt;
  logic [33:0] sb[$];
  logic [33:0] e;
  int tests = 0, fails = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, wait_cnt = 0, beat = 0;
  int last_wr_cyc = 0, done_at = 0;

  attn_rowmax_sched #(.T(4), .ROWS(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_rows(cfg_rows),
    .busy(busy), .done(done), .err(err),
    .sc_rd_en(sc_rd_en), .sc_rd_row(sc_rd_row), .sc_rd_col(sc_rd_col), .sc_rd_data(sc_rd_data),
    .rm_in_valid(rm_in_valid), .rm_in_fp32(rm_in_fp32), .rm_row_start(rm_row_start),
    .rm_row_last(rm_row_last), .rm_max_valid(rm_max_valid), .rm_max_fp32(rm_max_fp32),
    .mx_wr_en(mx_wr_en), .mx_wr_row(mx_wr_row), .mx_wr_data(mx_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (sc_rd_en) sc_rd_data <= mem[sc_rd_row][sc_rd_col];

  function automatic logic [31:0] key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction
  assign m_nxt = (rm_row_start || key(rm_in_fp32) > key(acc)) ? rm_in_fp32 : acc;
  always @(posedge clk) begin
    rm_max_valid <= 1'b0;
    if (rm_in_valid) begin
      acc <= m_nxt;
      if (rm_row_last) begin
        rm_max_valid <= stub_en;
        rm_max_fp32 <= m_nxt;
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (sc_rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (busy && !sc_rd_en && !mx_wr_en && !done) wait_cnt++;
    if (mx_wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wr: got row %0d data %h, expected no write", mx_wr_row, mx_wr_data);
      end else begin
        e = sb.pop_front();
        chk("mx_wr", {mx_wr_row, mx_wr_data}, e);
      end
    end
    if (rm_in_valid) begin
      chk("row_start", rm_row_start, beat == 0);
      chk("row_last", rm_row_last, beat == 3);
      beat++;
    end else if (beat != 0) begin
      chk("beats", beat, 4);
      beat = 0;
    end
  end

  task automatic clr();
    rd_cnt = 0; wr_cnt = 0; wait_cnt = 0;
  endtask
  task automatic kick(input int n);
    @(negedge clk);
    cfg_rows = 3'(n);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string n);
    for (int k = 0; k < 2000 && !done; k++) @(negedge clk);
    chk({n, "_done"}, done, 1);
    done_at = cyc;
    @(negedge clk);
    chk({n, "_idle"}, busy, 0);
  endtask
  task automatic push(input int r, input logic [31:0] d);
    sb.push_back({2'(r), d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int d0;
    mem[0] = '{32'h3DCCCCCD, 32'h3ECCCCCD, 32'h3E4CCCCD, 32'h3E99999A};
    mem[1] = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hBE800000};
    mem[2] = '{32'h40A00000, 32'h40400000, 32'h40E00000, 32'h40C00000};
    mem[3] = '{32'h3F800000, 32'h40000000, 32'h41000000, 32'h40800000};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", sc_rd_en, 0);
    chk("rst_wr", mx_wr_en, 0);
    chk("rst_inv", rm_in_valid, 0);
    rst = 0;
    // three rows, in-order writes, done right after last write
    clr();
    push(0, 32'h3ECCCCCD); push(1, 32'hBE800000); push(2, 32'h40E00000);
    kick(3);
    wait_done("t1");
    chk("t1_done_lat", done_at - last_wr_cyc, 1);
    chk("t1_err", err, 0);
    chk("t1_rd", rd_cnt, 12);
    chk("t1_wr", wr_cnt, 3);
    // zero rows and clamped rows
    clr();
    kick(0);
    wait_done("t2a");
    chk("t2a_rd", rd_cnt, 0);
    chk("t2a_wr", wr_cnt, 0);
    clr();
    push(0, 32'h3ECCCCCD); push(1, 32'hBE800000); push(2, 32'h40E00000); push(3, 32'h41000000);
    kick(7);
    wait_done("t2b");
    chk("t2b_rd", rd_cnt, 16);
    chk("t2b_wr", wr_cnt, 4);
    // datapath timeout
    stub_en = 0;
    clr();
    kick(1);
    wait_done("t3");
    chk("t3_err", err, 1);
    chk("t3_rd", rd_cnt, 4);
    chk("t3_wr", wr_cnt, 0);
    chk("t3_wait", wait_cnt, 64);
    repeat (5) @(negedge clk);
    chk("t3_err_sticky", err, 1);
    stub_en = 1;
    clr();
    push(0, 32'h3ECCCCCD);
    kick(1);
    chk("t3_err_clr", err, 0);
    wait_done("t3b");
    // abort during row 1 issue
    clr();
    push(0, 32'h3ECCCCCD);
    kick(2);
    for (int k = 0; k < 500 && !(sc_rd_en && sc_rd_row == 1); k++) @(negedge clk);
    chk("t4_row1_seen", sc_rd_en && sc_rd_row == 1, 1);
    abort = 1;
    d0 = done_cnt;
    @(negedge clk);
    abort = 0;
    chk("t4_busy", busy, 0);
    chk("t4_inv", rm_in_valid, 0);
    repeat (10) @(negedge clk);
    chk("t4_no_done", done_cnt, d0);
    chk("t4_wr", wr_cnt, 1);
    chk("t4_sb", sb.size(), 0);
    chk("t4_err", err, 0);
    clr();
    push(0, 32'h3ECCCCCD);
    kick(1);
    wait_done("t4b");
    chk("t4b_rd", rd_cnt, 4);
    // start while busy is ignored
    clr();
    d0 = done_cnt;
    push(0, 32'h3ECCCCCD); push(1, 32'hBE800000);
    kick(2);
    repeat (3) @(negedge clk);
    cfg_rows = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("t5");
    repeat (20) @(negedge clk);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_wr", wr_cnt, 2);
    chk("t5_rd", rd_cnt, 8);
    // async reset in WAIT
    stub_en = 0;
    clr();
    kick(1);
    for (int k = 0; k < 100 && !(busy && !sc_rd_en && !done && !mx_wr_en); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t5_in_wait", busy && !sc_rd_en, 1);
    d0 = done_cnt;
    #2 rst = 1;
    #1;
    chk("t5r_busy", busy, 0);
    chk("t5r_done", done, 0);
    chk("t5r_err", err, 0);
    chk("t5r_rd", sc_rd_en, 0);
    chk("t5r_wr", mx_wr_en, 0);
    chk("t5r_flags", {rm_in_valid, rm_row_start, rm_row_last}, 0);
    chk("t5r_idx", {sc_rd_row, sc_rd_col, mx_wr_row, mx_wr_data}, 0);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("t5r_no_done", done_cnt, d0);
    stub_en = 1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
